// File: rtl/cm0_dap_pkg.sv
// Shared DAP definitions: FSM encoding, DP<->AP bus layouts and widths.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Bus layouts (LSB first):
//   dp->ap (38b): req[0], data[32:1], regaddr[36:33], rnw[37]
//   ap->dp (34b): ack[0], err[1], data[33:2]
package cm0_dap_pkg;

  localparam int DP2AP_W = 38;
  localparam int AP2DP_W = 34;
  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 4;

  // dp->ap bit positions
  localparam int DP2AP_REQ      = 0;
  localparam int DP2AP_DATA_LSB = 1;
  localparam int DP2AP_DATA_MSB = 32;
  localparam int DP2AP_ADDR_LSB = 33;
  localparam int DP2AP_ADDR_MSB = 36;
  localparam int DP2AP_RNW      = 37;

  // ap->dp bit positions
  localparam int AP2DP_ACK      = 0;
  localparam int AP2DP_ERR      = 1;
  localparam int AP2DP_DATA_LSB = 2;
  localparam int AP2DP_DATA_MSB = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } apacc_state_t;

  // Field order matches the bit positions above.
  typedef struct packed {
    logic              rnw;
    logic [ADDR_W-1:0] regaddr;
    logic [DATA_W-1:0] data;
    logic              req;
  } dp_to_ap_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              err;
    logic              ack;
  } ap_to_dp_t;

endpackage

// File: rtl/cm0_dap_dp_apacc_if.sv
// APACC access channel between the DP protocol engine and the AP access block.
// Latency: n/a (wires only).
// Backpressure: slave answers each acc_valid with ready, wait or fault in the same cycle.
//
// master = protocol engine, slave = cm0_dap_dp_apacc.
interface cm0_dap_dp_apacc_if;
  import cm0_dap_pkg::*;

  logic              acc_valid;
  logic              acc_rnw;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_ready;
  logic              acc_wait;
  logic              acc_fault;
  logic              acc_done;
  logic [DATA_W-1:0] rdbuff;

  modport master (
    output acc_valid, acc_rnw, acc_addr, acc_wdata,
    input  acc_ready, acc_wait, acc_fault, acc_done, rdbuff
  );

  modport slave (
    input  acc_valid, acc_rnw, acc_addr, acc_wdata,
    output acc_ready, acc_wait, acc_fault, acc_done, rdbuff
  );

endinterface

// File: rtl/cm0_dap_sync.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// Latency: STAGES clk cycles from d to q.
// Backpressure: none.
//
// Ports: clk, rst (sync, active-high, clears the chain), d (async in), q (synchronised out).
module cm0_dap_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/cm0_dap_dp_apacc.sv
// APACC bridge: turns DP access requests into a 4-phase req/ack handshake to the AP.
// Latency: req rises the cycle after accept; acc_done SYNC_STAGES cycles after AP ack rises.
// Backpressure: one transfer in flight; acc_valid while busy gets acc_wait, with sticky error acc_fault.
//
// Ports: dclk, dpreset (sync, active-high); acc (APACC channel, slave side);
//        clr_sticky, abort (DP controls); sticky_err, busy (status);
//        cm0_dap_dp_to_ap (38b request bus), cm0_dap_ap_to_dp (34b response bus, async to dclk).
module cm0_dap_dp_apacc
  import cm0_dap_pkg::*;
#(
  parameter int PRESENT     = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic                dclk,
  input  logic                dpreset,
  cm0_dap_dp_apacc_if.slave   acc,
  input  logic                clr_sticky,
  input  logic                abort,
  output logic                sticky_err,
  output logic                busy,
  output logic [DP2AP_W-1:0]  cm0_dap_dp_to_ap,
  input  logic [AP2DP_W-1:0]  cm0_dap_ap_to_dp
);

  localparam bit HAS_AP = (PRESENT != 0);

  apacc_state_t      state;
  apacc_state_t      state_nxt;

  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdbuff_q;
  logic              sticky_q;
  logic              abort_q;
  logic              armed_q;
  logic              done_q;

  logic              ack_s;
  logic              ack_seen;
  logic              discard;
  logic              acc_ready_c;
  logic              acc_wait_c;
  logic              acc_fault_c;
  logic              xfer_done_c;

  ap_to_dp_t         ap_in;
  dp_to_ap_t         ap_out;

  assign ap_in = cm0_dap_ap_to_dp;

  // Only ack crosses the synchroniser; data/err are held stable by the AP while ack is high.
  cm0_dap_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk (dclk),
    .rst (dpreset),
    .d   (ap_in.ack),
    .q   (ack_s)
  );

  // An ack only counts once ack_s has been seen low inside REQ. A legitimate ack cannot
  // reach ack_s in the first REQ cycle, so this costs no latency, but it keeps a stale
  // ack from a handshake cut short by reset from completing the next transfer.
  assign ack_seen = ack_s && armed_q;

  // Abort on the completing cycle discards the result as well.
  assign discard = abort_q || abort;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge dclk) begin
    if (dpreset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (acc_ready_c && HAS_AP) state_nxt = ST_REQ;
      ST_REQ:  if (ack_seen)              state_nxt = ST_REL;
      ST_REL:  if (!ack_s)                state_nxt = ST_IDLE;
      default:                            state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Gated by dpreset so nothing is accepted or reported on a cycle that is being reset.
  always_comb begin
    acc_ready_c = 1'b0;
    acc_wait_c  = 1'b0;
    acc_fault_c = 1'b0;
    xfer_done_c = 1'b0;
    if (!dpreset) begin
      case (state)
        ST_IDLE: begin
          if (acc.acc_valid) begin
            // Uses the registered flag, so a same-cycle clr_sticky still faults.
            if (sticky_q) acc_fault_c = 1'b1;
            else          acc_ready_c = 1'b1;
          end
        end
        ST_REQ: begin
          acc_wait_c  = acc.acc_valid;
          xfer_done_c = ack_seen && !discard;
        end
        ST_REL: begin
          acc_wait_c = acc.acc_valid;
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge dclk) begin
    if (dpreset) begin
      rnw_q    <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdbuff_q <= '0;
      sticky_q <= 1'b0;
      abort_q  <= 1'b0;
      armed_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      // With no AP an accept completes on its own one cycle later.
      done_q <= !HAS_AP && acc_ready_c;

      if (acc_ready_c) begin
        abort_q <= 1'b0;
        armed_q <= 1'b0;
        if (HAS_AP) begin
          rnw_q   <= acc.acc_rnw;
          addr_q  <= acc.acc_addr;
          wdata_q <= acc.acc_wdata;
        end else begin
          rdbuff_q <= '0;
        end
      end

      if (state == ST_REQ) begin
        if (abort)  abort_q <= 1'b1;
        if (!ack_s) armed_q <= 1'b1;
      end

      if (xfer_done_c && rnw_q) rdbuff_q <= ap_in.data;

      // A new error outranks a coincident clear.
      if (xfer_done_c && ap_in.err) sticky_q <= 1'b1;
      else if (clr_sticky)          sticky_q <= 1'b0;
    end
  end

  always_comb begin
    ap_out         = '0;
    ap_out.rnw     = rnw_q;
    ap_out.regaddr = addr_q;
    ap_out.data    = wdata_q;
    ap_out.req     = (state == ST_REQ);
  end

  assign cm0_dap_dp_to_ap = ap_out;

  assign acc.acc_ready = acc_ready_c;
  assign acc.acc_wait  = acc_wait_c;
  assign acc.acc_fault = acc_fault_c;
  assign acc.acc_done  = HAS_AP ? xfer_done_c : done_q;
  assign acc.rdbuff    = rdbuff_q;

  assign sticky_err = sticky_q;
  assign busy       = (state != ST_IDLE);

endmodule

// File: doc/cm0_dap_dp_apacc.md
CM0_DAP_DP_APACC -- requirements
Module: cm0_dap_dp_apacc

Interface
REQ-001 Parameter PRESENT, default 1: AP present; 0 means no handshake is ever issued.
REQ-002 Parameter SYNC_STAGES, default 2 (legal 2..3): synchroniser depth on the incoming AP ack.
REQ-003 dclk  in  1  DP clock; the block has one clock; all flops rise on dclk.
REQ-004 dpreset  in  1  reset; synchronous, active-high.
REQ-005 acc_valid  in  1  APACC access request from DP protocol engine.
REQ-006 acc_rnw  in  1  1 = read, 0 = write.
REQ-007 acc_addr  in  4  AP register address.
REQ-008 acc_wdata  in  32  write data.
REQ-009 acc_ready  out  1  access accepted this cycle.
REQ-010 acc_wait  out  1  access refused, engine returns WAIT.
REQ-011 acc_fault  out  1  access refused, sticky error set, engine returns FAULT.
REQ-012 acc_done  out  1  one-cycle pulse: transfer complete, rdbuff/sticky_err updated.
REQ-013 rdbuff  out  32  data from the last completed read.
REQ-014 sticky_err  out  1  sticky AP error flag.
REQ-015 clr_sticky  in  1  clears sticky_err.
REQ-016 abort  in  1  DP ABORT request.
REQ-017 busy  out  1  state != IDLE.
REQ-018 cm0_dap_dp_to_ap  out  38  {rnw[37], regaddr[36:33], data[32:1], req[0]}.
REQ-019 cm0_dap_ap_to_dp  in  34  {data[33:2], err[1], ack[0]}, asynchronous to dclk.

Function
REQ-020 The FSM SHALL have states IDLE, REQ, REL.
REQ-021 In IDLE, acc_valid with sticky_err=0 SHALL assert acc_ready combinationally, latch rnw/addr/wdata, and move to REQ.
REQ-022 In IDLE, acc_valid with sticky_err=1 SHALL assert acc_fault, start no transfer, and stay in IDLE.
REQ-023 acc_valid in REQ or REL SHALL assert acc_wait only.
REQ-024 req SHALL be 1 exactly in REQ; rnw, regaddr and data SHALL stay stable from the cycle after accept until the FSM returns to IDLE.
REQ-025 ack[0] SHALL pass through a SYNC_STAGES flop synchroniser (ack_s); data and err are sampled only when ack_s=1.
REQ-026 In REQ with ack_s=1: capture data into rdbuff if rnw=1; set sticky_err if err=1; pulse acc_done; go to REL.
REQ-027 In REL with ack_s=0: go to IDLE.
REQ-028 An AP ack is latency-unbounded; there is no timeout.
REQ-029 abort in REQ SHALL NOT drop req. The 4-phase handshake completes, but the result is discarded: no rdbuff or sticky update and no acc_done.
REQ-030 abort in IDLE or REL SHALL have no effect.
REQ-031 clr_sticky SHALL clear sticky_err next cycle. If it coincides with a set in REQ-026, the set wins.
REQ-032 acc_fault in REQ-022 SHALL evaluate sticky_err before any same-cycle clr_sticky.
REQ-033 With PRESENT=0, accepts SHALL pulse acc_done the next cycle, rdbuff SHALL load 0, req SHALL stay 0, and the FSM SHALL stay in IDLE.
REQ-034 Minimum latency: accept at cycle N, req=1 at N+1; AP ack high at cycle M gives acc_done at M+SYNC_STAGES.

Reset
REQ-035 On dpreset=1 at a dclk edge, the block SHALL reset to:
- FSM IDLE
- req 0
- bus fields 0
- synchroniser 0
- rdbuff 0
- sticky_err 0
- abort flag 0
- all pulse outputs 0
REQ-036 Reset mid-handshake SHALL drop req immediately; acks arriving after reset SHALL be ignored until a new accept.

Structure
REQ-037 A shared package cm0_dap_pkg SHALL hold:
- state encoding
- bus bit-position constants for both 38-bit and 34-bit buses
- widths 38/34/32/4
REQ-038 The block SHALL contain one sub-module, cm0_dap_sync (SYNC_STAGES-deep synchroniser), reused by the AP side.

Verification
REQ-039 Read: acc_valid, rnw=1, addr=4'h3; AP model acks 3 cycles after req with data 32'hDEADBEEF, err=0. Required: acc_done once, rdbuff=32'hDEADBEEF, sticky_err=0, req low after ack_s.
REQ-040 Write: acc_wdata=32'h12345678, addr=4'h0. Required: bus data field 32'h12345678 stable from req rise until return to IDLE, rnw=0.
REQ-041 Error: ack with err=1. Required: sticky_err=1. Next acc_valid gives acc_fault and no req. clr_sticky then acc_valid gives acc_ready.
REQ-042 Back-to-back: acc_valid held through a transfer. Required: acc_wait=1 in REQ/REL, acc_ready in the first IDLE cycle.
REQ-043 Abort in REQ, read data 32'hCAFE0000. Required: handshake completes, rdbuff unchanged, no acc_done.
REQ-044 dpreset asserted in REQ with ack pending. Required: next cycle req=0, FSM IDLE, all outputs at reset values.
